// File: rtl/inta_sequencer.sv
// CPU-side INTA initiator for an 8259 PIC: synchronizes INT, issues the two-pulse
// acknowledge, captures the vector on pulse 2 and hands it to the core via valid/ready.
module inta_sequencer #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT,
  input  logic       int_enable,
  input  logic [7:0] data_bus,
  output logic       int_ack,
  output logic       bus_lock,
  output logic       busy,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       vector_ready
);

  localparam int unsigned MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACK1_LOW = 3'd1,
    ACK1_GAP = 3'd2,
    ACK2_LOW = 3'd3,
    HOLD     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              int_sync;
  logic              int_ack_q, int_ack_d;
  logic              bus_lock_q, bus_lock_d;
  logic              busy_q, busy_d;
  logic [7:0]        vector_q, vector_d;
  logic              valid_q, valid_d;

  // INT is asynchronous; only the last synchronizer stage is used by the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], INT};
  end

  assign int_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      int_ack_q  <= 1'b1;
      bus_lock_q <= 1'b0;
      busy_q     <= 1'b0;
      vector_q   <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_ack_q  <= int_ack_d;
      bus_lock_q <= bus_lock_d;
      busy_q     <= busy_d;
      vector_q   <= vector_d;
      valid_q    <= valid_d;
    end
  end

  // Next state; the counter restarts at zero whenever a state is entered
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    vector_d = vector_q;
    valid_d  = valid_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (int_sync && int_enable) state_d = ACK1_LOW;
      end
      ACK1_LOW: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ACK1_GAP;
          cnt_d   = '0;
        end
      end
      ACK1_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ACK2_LOW;
          cnt_d   = '0;
        end
      end
      ACK2_LOW: begin
        if (cnt_q == PULSE_LAST) begin
          state_d  = HOLD;
          cnt_d    = '0;
          vector_d = data_bus;
          valid_d  = 1'b1;
        end
      end
      HOLD: begin
        cnt_d = '0;
        if (vector_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Pin outputs decoded from the next state so they move on the same edge as the FSM
  always_comb begin
    int_ack_d  = 1'b1;
    bus_lock_d = 1'b0;
    busy_d     = 1'b0;
    if (state_d == ACK1_LOW || state_d == ACK2_LOW) int_ack_d = 1'b0;
    if (state_d == ACK1_LOW || state_d == ACK1_GAP || state_d == ACK2_LOW) bus_lock_d = 1'b1;
    if (state_d != IDLE) busy_d = 1'b1;
  end

  assign int_ack      = int_ack_q;
  assign bus_lock     = bus_lock_q;
  assign busy         = busy_q;
  assign vector       = vector_q;
  assign vector_valid = valid_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer at default parameters (PULSE=4, GAP=2, SYNC=2).
module tb_inta_sequencer;

  logic       clk;
  logic       reset;
  logic       INT;
  logic       int_enable;
  logic [7:0] data_bus;
  logic       int_ack;
  logic       bus_lock;
  logic       busy;
  logic [7:0] vector;
  logic       vector_valid;
  logic       vector_ready;

  int checks;
  int errors;

  logic [13:0] ack_pat;
  logic [13:0] lock_pat;
  logic [13:0] valid_pat;
  logic        ack_all;
  logic        busy_any;
  logic        vec_stable;
  logic        valid_all;

  inta_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .INT          (INT),
    .int_enable   (int_enable),
    .data_bus     (data_bus),
    .int_ack      (int_ack),
    .bus_lock     (bus_lock),
    .busy         (busy),
    .vector       (vector),
    .vector_valid (vector_valid),
    .vector_ready (vector_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit later
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    INT          = 1'b0;
    int_enable   = 1'b0;
    data_bus     = 8'h00;
    vector_ready = 1'b0;
    tick(2);
    chk("rst_int_ack", 32'(int_ack), 32'd1);
    chk("rst_bus_lock", 32'(bus_lock), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vector", 32'(vector), 32'h00);
    chk("rst_valid", 32'(vector_valid), 32'd0);
    reset = 1'b0;
    tick(2);

    // Basic sequence: 2 sync edges, then low 4 / high 2 / low 4
    int_enable = 1'b1;
    INT        = 1'b1;
    data_bus   = 8'h4B;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      ack_pat   = {ack_pat[12:0], int_ack};
      lock_pat  = {lock_pat[12:0], bus_lock};
      valid_pat = {valid_pat[12:0], vector_valid};
    end
    chk("basic_ack_pattern", 32'(ack_pat), 32'h30C3);
    chk("basic_lock_pattern", 32'(lock_pat), 32'h0FFC);
    chk("basic_valid_pattern", 32'(valid_pat), 32'h0003);
    chk("basic_vector", 32'(vector), 32'h4B);
    chk("basic_busy_hold", 32'(busy), 32'd1);
    INT = 1'b0;
    tick(3);
    chk("basic_valid_waiting", 32'(vector_valid), 32'd1);
    vector_ready = 1'b1;
    tick(1);
    chk("basic_valid_cleared", 32'(vector_valid), 32'd0);
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_vector_kept", 32'(vector), 32'h4B);
    vector_ready = 1'b0;
    tick(3);
    chk("basic_no_restart", 32'(int_ack), 32'd1);

    // INT drops in the gap; ready held early is ignored until HOLD has lasted a cycle
    INT      = 1'b1;
    data_bus = 8'h47;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (i == 6) begin
        INT          = 1'b0;
        vector_ready = 1'b1;
      end
      ack_pat   = {ack_pat[12:0], int_ack};
      valid_pat = {valid_pat[12:0], vector_valid};
    end
    chk("drop_ack_pattern", 32'(ack_pat), 32'h30C3);
    chk("drop_valid_pattern", 32'(valid_pat), 32'h0002);
    chk("drop_vector", 32'(vector), 32'h47);
    chk("drop_idle_busy", 32'(busy), 32'd0);
    vector_ready = 1'b0;

    // Interrupts disabled for 20 cycles
    int_enable = 1'b0;
    INT        = 1'b1;
    data_bus   = 8'hA5;
    ack_all    = 1'b1;
    busy_any   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      ack_all  = ack_all & int_ack;
      busy_any = busy_any | busy;
    end
    chk("dis_ack_high", 32'(ack_all), 32'd1);
    chk("dis_busy_low", 32'(busy_any), 32'd0);
    int_enable = 1'b1;
    tick(1);
    chk("en_first_pulse", 32'(int_ack), 32'd0);
    tick(9);
    chk("en_valid_not_yet", 32'(vector_valid), 32'd0);
    tick(1);
    chk("en_valid", 32'(vector_valid), 32'd1);
    chk("en_vector", 32'(vector), 32'hA5);

    // Back-pressure with INT still high
    data_bus   = 8'hFF;
    ack_all    = 1'b1;
    vec_stable = 1'b1;
    valid_all  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      ack_all    = ack_all & int_ack;
      vec_stable = vec_stable & (vector == 8'hA5);
      valid_all  = valid_all & vector_valid;
    end
    chk("bp_no_pulse", 32'(ack_all), 32'd1);
    chk("bp_vector_stable", 32'(vec_stable), 32'd1);
    chk("bp_valid_held", 32'(valid_all), 32'd1);
    vector_ready = 1'b1;
    tick(1);
    chk("bp_consumed", 32'(vector_valid), 32'd0);
    chk("bp_idle_ack", 32'(int_ack), 32'd1);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    vector_ready = 1'b0;
    tick(1);
    chk("bp_restart_ack", 32'(int_ack), 32'd0);
    chk("bp_restart_lock", 32'(bus_lock), 32'd1);

    // Asynchronous reset in the middle of pulse 1
    tick(1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(int_ack), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(vector_valid), 32'd0);
    chk("mid_rst_lock", 32'(bus_lock), 32'd0);
    chk("mid_rst_vector", 32'(vector), 32'h00);
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("post_rst_sync_wait", 32'(int_ack), 32'd1);
    tick(1);
    chk("post_rst_restart", 32'(int_ack), 32'd0);
    INT      = 1'b0;
    data_bus = 8'h3C;
    tick(10);
    chk("post_rst_valid", 32'(vector_valid), 32'd1);
    chk("post_rst_vector", 32'(vector), 32'h3C);

    // One-cycle INT glitch while in HOLD
    tick(1);
    INT = 1'b1;
    tick(1);
    INT = 1'b0;
    tick(4);
    vector_ready = 1'b1;
    tick(1);
    chk("glitch_consumed", 32'(vector_valid), 32'd0);
    vector_ready = 1'b0;
    ack_all  = 1'b1;
    busy_any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      ack_all  = ack_all & int_ack;
      busy_any = busy_any | busy;
    end
    chk("glitch_no_pulse", 32'(ack_all), 32'd1);
    chk("glitch_idle", 32'(busy_any), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
